core_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the single-issue RISC-V core datapath (PC, IMEM, register file, ALU). Each instruction moves through FETCH, DECODE, EXECUTE and WRITEBACK. The block latches the fetched instruction, decodes the supported R-type subset and drives the datapath strobes: PC write enable, register-file write enable and ALU operation select. It also halts on ECALL and flags unsupported encodings.

---
 rtl/core_ctrl_fsm.sv | 115 +++++++++++
 tb/tb_core_ctrl_fsm.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer
// for the single-issue core; decodes ADD/SUB/AND/OR, halts on ECALL.
module core_ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      inst_i,
    input  logic             imem_ready_i,
    output logic             pc_we_o,
    output logic             ir_we_o,
    output logic             reg_we_o,
    output logic [1:0]       alu_op_o,
    output logic             illegal_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      ir;
    logic [1:0]       alu_op;
    logic             illegal_q;
    logic             wr_q;
    logic [CNT_W-1:0] retired;

    logic [1:0]       dec_op;
    logic             dec_legal;
    logic             dec_ecall;

    // Classify the latched instruction into the supported R-type subset.
    always_comb begin
        dec_op    = 2'b00;
        dec_legal = 1'b0;
        dec_ecall = (ir == 32'h0000_0073);
        if (ir[6:0] == 7'b0110011) begin
            case ({ir[31:25], ir[14:12]})
                10'b0000000_000: begin dec_op = 2'b00; dec_legal = 1'b1; end
                10'b0100000_000: begin dec_op = 2'b01; dec_legal = 1'b1; end
                10'b0000000_111: begin dec_op = 2'b10; dec_legal = 1'b1; end
                10'b0000000_110: begin dec_op = 2'b11; dec_legal = 1'b1; end
                default:         begin dec_op = 2'b00; dec_legal = 1'b0; end
            endcase
        end
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next-state and strobes, decoded only from registered state.
    always_comb begin
        state_nxt = state;
        pc_we_o   = 1'b0;
        ir_we_o   = 1'b0;
        reg_we_o  = 1'b0;
        illegal_o = 1'b0;
        halt_o    = 1'b0;
        case (state)
            S_FETCH: begin
                if (imem_ready_i) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ir_we_o   = 1'b1;
                state_nxt = dec_ecall ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                illegal_o = illegal_q;
                state_nxt = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_we_o   = 1'b1;
                reg_we_o  = wr_q;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halt_o    = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // IR capture, decoded op/flags and the retired-instruction counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir        <= '0;
            alu_op    <= 2'b00;
            illegal_q <= 1'b0;
            wr_q      <= 1'b0;
            retired   <= '0;
        end else begin
            if (state == S_FETCH && imem_ready_i) ir <= inst_i;
            if (state == S_DECODE) begin
                alu_op    <= dec_op;
                illegal_q <= !dec_legal && !dec_ecall;
                wr_q      <= dec_legal && (ir[11:7] != 5'd0);
            end
            if (state == S_WRITEBACK) retired <= retired + CNT_W'(1);
        end
    end

    assign alu_op_o  = alu_op;
    assign retired_o = retired;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: directed cycle-accurate checks of the control
// sequencer, including counter wrap, ECALL halt and mid-flight reset.
module tb_core_ctrl_fsm;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   inst;
    logic          ready;
    logic          pc_we;
    logic          ir_we;
    logic          reg_we;
    logic [1:0]    alu_op;
    logic          illegal;
    logic          halt;
    logic [CW-1:0] retired;

    int checks;
    int failures;
    int cyc;
    int exp_ret;

    logic [4:0] st;
    assign st = {ir_we, pc_we, reg_we, illegal, halt};

    core_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .inst_i       (inst),
        .imem_ready_i (ready),
        .pc_we_o      (pc_we),
        .ir_we_o      (ir_we),
        .reg_we_o     (reg_we),
        .alu_op_o     (alu_op),
        .illegal_o    (illegal),
        .halt_o       (halt),
        .retired_o    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Caller is at a negedge with the DUT in FETCH.
    task automatic run_inst(input logic [31:0] iw, input int wait_n,
                            input logic [1:0] op, input logic ill,
                            input logic rwe);
        int t0;
        t0 = cyc;
        for (int i = 0; i < wait_n; i++) begin
            ready = 1'b0;
            inst  = $urandom;
            check("wait_strobes", {27'd0, st}, 32'd0);
            @(negedge clk);
        end
        ready = 1'b1;
        inst  = iw;
        check("fetch_strobes", {27'd0, st}, 32'd0);
        @(negedge clk);
        ready = 1'($urandom);
        inst  = $urandom;
        check("decode_strobes", {27'd0, st}, 32'b10000);
        @(negedge clk);
        check("exec_strobes", {27'd0, st}, {27'd0, 3'b000, ill, 1'b0});
        check("exec_alu_op", {30'd0, alu_op}, {30'd0, op});
        @(negedge clk);
        ready = 1'b0;
        check("wb_strobes", {27'd0, st}, {27'd0, 1'b0, 1'b1, rwe, 2'b00});
        check("wb_alu_op", {30'd0, alu_op}, {30'd0, op});
        @(negedge clk);
        exp_ret = (exp_ret + 1) % (1 << CW);
        check("retired", {28'd0, retired}, exp_ret);
        check("latency", cyc - t0, wait_n + 4);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_ret  = 0;
        rst      = 1'b1;
        ready    = 1'b1;
        inst     = 32'h002081B3;
        repeat (3) @(negedge clk);
        check("rst_strobes", {27'd0, st}, 32'd0);
        check("rst_alu_op", {30'd0, alu_op}, 32'd0);
        check("rst_retired", {28'd0, retired}, 32'd0);
        rst   = 1'b0;
        ready = 1'b0;

        run_inst(32'h002081B3, 0, 2'b00, 1'b0, 1'b1);
        run_inst(32'h402081B3, 0, 2'b01, 1'b0, 1'b1);
        run_inst(32'h0020F1B3, 0, 2'b10, 1'b0, 1'b1);
        run_inst(32'h0020E1B3, 0, 2'b11, 1'b0, 1'b1);
        check("retired_4", {28'd0, retired}, 32'd4);
        run_inst(32'h00000013, 0, 2'b00, 1'b1, 1'b0);
        run_inst(32'h00208033, 0, 2'b00, 1'b0, 1'b0);
        run_inst(32'h002081B3, 5, 2'b00, 1'b0, 1'b1);
        run_inst(32'h0000F1B3, 0, 2'b10, 1'b0, 1'b1);
        run_inst(32'h0020E0B3, 2, 2'b11, 1'b0, 1'b1);
        run_inst(32'h4020E1B3, 0, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++)
            run_inst(32'h402081B3, k % 2, 2'b01, 1'b0, 1'b1);
        check("retired_wrap", {28'd0, retired}, 32'd0);

        ready = 1'b1;
        inst  = 32'h00000073;
        check("ecall_fetch", {27'd0, st}, 32'd0);
        @(negedge clk);
        inst = 32'h002081B3;
        check("ecall_decode", {27'd0, st}, 32'b10000);
        @(negedge clk);
        check("ecall_halt", {27'd0, st}, 32'b00001);
        check("ecall_retired", {28'd0, retired}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            ready = 1'($urandom);
            inst  = (i % 3 == 0) ? 32'h002081B3 : $urandom;
            @(negedge clk);
            check("halt_hold", {27'd0, st}, 32'b00001);
        end
        check("halt_retired", {28'd0, retired}, 32'd0);

        rst = 1'b1;
        #1;
        check("halt_rst", {27'd0, st}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b1;
        inst  = 32'h002081B3;
        @(negedge clk);
        check("abort_decode", {27'd0, st}, 32'b10000);
        rst = 1'b1;
        #1;
        check("abort_strobes", {27'd0, st}, 32'd0);
        check("abort_alu_op", {30'd0, alu_op}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", {27'd0, st}, 32'd0);
        end
        check("post_rst_retired", {28'd0, retired}, 32'd0);
        exp_ret = 0;
        run_inst(32'h002081B3, 0, 2'b00, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
